// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a word-addressed 16-bit data memory.
// Handles one load/store at a time; byte stores are done as read-modify-write.
module mem_access_ctrl #(
  parameter int AW        = 16,
  parameter int READ_WAIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_byte,
  input  logic          req_lane,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_wdata,
  output logic          resp_valid,
  output logic [15:0]   resp_rdata,
  output logic          busy,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic          r_byte;
  logic          r_lane;
  logic          r_signed;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic [15:0]   r_rbuf;
  logic [15:0]   r_resp_rdata;

  logic          w_accept;
  logic          w_rd_done;
  logic [7:0]    w_rd_byte;
  logic [15:0]   w_load_ext;
  logic [15:0]   w_merged;

  assign w_accept  = req_valid && req_ready;
  assign w_rd_done = (r_cnt == 4'(READ_WAIT));

  // Load result is formed straight from the sampled word so it is ready in RESP.
  assign w_rd_byte  = r_lane ? mem_rdata[15:8] : mem_rdata[7:0];
  assign w_load_ext = r_byte ? {(r_signed ? {8{w_rd_byte[7]}} : 8'h00), w_rd_byte}
                             : mem_rdata;

  assign w_merged = !r_byte ? r_wdata :
                    r_lane  ? {r_wdata[7:0], r_rbuf[7:0]} :
                              {r_rbuf[15:8], r_wdata[7:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_byte       <= 1'b0;
      r_lane       <= 1'b0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rbuf       <= '0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= req_write;
            r_byte   <= req_byte;
            r_lane   <= req_lane;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= '0;
            r_state  <= (req_write && !req_byte) ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (w_rd_done) begin
            r_rbuf <= mem_rdata;
            if (r_write) begin
              r_state <= S_WRITE;
            end else begin
              r_resp_rdata <= w_load_ext;
              r_state      <= S_RESP;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WRITE: begin
          r_resp_rdata <= '0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so the pipeline sees a stall while held in reset.
  assign req_ready  = rst_n && (r_state == S_IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign mem_read   = (r_state == S_READ);
  assign mem_write  = (r_state == S_WRITE);
  assign mem_addr   = r_addr;
  assign mem_wdata  = (r_state == S_WRITE) ? w_merged : 16'h0000;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage initiator for the 16-bit word-addressed data memory. It accepts one load/store request at a time from the pipeline and drives the memory's read strobe, write strobe, address and write data. It captures read data and returns load results with byte-select and sign/zero extension. Byte stores are performed as read-modify-write, because the memory is only word-writable.

Parameters:
AW, 16, word-address width driven to data memory
READ_WAIT, 0, extra cycles mem_read is held before mem_rdata is sampled (0..15)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  pipeline request present
req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready at clk edge
req_write  in  1  1=store, 0=load
req_byte  in  1  1=byte access, 0=16-bit word access
req_lane  in  1  byte lane: 0=bits[7:0], 1=bits[15:8]; ignored for word access
req_signed  in  1  byte load: 1=sign-extend, 0=zero-extend
req_addr  in  AW  word address
req_wdata  in  16  store data; byte store uses bits[7:0]
resp_valid  out  1  one-cycle pulse, request complete
resp_rdata  out  16  load result, valid with resp_valid; 0 for stores
busy  out  1  ~req_ready (pipeline stall)
mem_read  out  1  data-memory read enable
mem_write  out  1  data-memory write enable, written at clk edge
mem_addr  out  AW  data-memory address
mem_wdata  out  16  data-memory write data
mem_rdata  in  16  data-memory read data, combinational from mem_addr while mem_read=1

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, wait counter=0, all latched request fields=0. Outputs after that edge: resp_valid=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. req_ready=0 while rst_n is low, 1 in the first cycle after rst_n goes high.
- Mem strobes are decoded from the state (Moore). mem_read and mem_write are never both 1.
- mem_addr always equals the latched address. mem_wdata equals the latched data or merged word in WRITE, else 0.
- States:
  - IDLE: req_ready=1. On accept, latch all req_* fields. Word store -> WRITE. Load or byte store -> READ with counter=0.
  - READ: mem_read=1. When counter==READ_WAIT, register mem_rdata into rbuf. Load -> RESP. Byte store -> WRITE. Otherwise counter+1.
  - WRITE: mem_write=1 for exactly one cycle.
    - Word store: mem_wdata=latched wdata.
    - Byte store: mem_wdata=rbuf with the selected lane replaced by wdata[7:0]; the other lane is unchanged.
    - Next state -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE.
- resp_rdata:
  - Word load: rbuf.
  - Byte load: selected lane in [7:0]; [15:8] = sign bit replicated if signed, else 0.
  - Stores: 0.
  - Held until the next resp_valid.
- Latency, accept edge to resp_valid cycle:
  - Word store: 2 cycles.
  - Load: 2+READ_WAIT cycles.
  - Byte store: 3+READ_WAIT cycles.
- Throughput: a new request can be accepted in the cycle after RESP (IDLE). There is no overlap.
- Requests while busy: req_valid is ignored while req_ready=0. The requester holds the request. Latched fields do not change mid-operation.
- Reset mid-operation: the operation is abandoned with no response. If reset hits during READ of a byte store, no write is ever issued. mem_write drops after the reset edge.
- Address wrap: none. The address is passed through unchanged.

Test Plan:
1. Word store: store addr 0x0010 data 0xBEEF -> mem_write=1 one cycle with mem_addr=0x0010, mem_wdata=0xBEEF; resp_valid 2 cycles after accept; then a word load of 0x0010 -> resp_rdata=0xBEEF.
2. Byte store lane 1: mem[0x0020]=0x1234, byte store lane1 data 0x00AB -> one mem_read cycle then one mem_write with mem_wdata=0xAB34; resp_valid 3 cycles after accept.
3. Byte load extension: mem[0x0030]=0x80F0 -> lane0 signed gives 0xFFF0, lane0 unsigned gives 0x00F0, lane1 signed gives 0xFF80.
4. READ_WAIT=2: word load -> mem_read high 3 cycles, resp_valid 4 cycles after accept, correct data; req_ready=0 throughout.
5. Held request and back-to-back: req_valid held high with changing req_addr while busy -> only the value present at the IDLE edge is used; the next request is accepted the cycle after RESP.
6. Reset during byte-store READ: assert rst_n=0 -> no mem_write ever, no resp_valid, all outputs 0; after release req_ready=1 and memory contents unchanged.
